// File: rtl/i2s_modport_pkg.sv
// Shared types and frame constants for the i2s_modport dual-link I2S master.
// Optional RX path is enabled with `define I2S_MODPORT_RX_EN.
package i2s_modport_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned FRAME_SLOTS = 64;

    typedef logic [5:0]        slot_t;
    typedef logic [WORD_W-1:0] word_t;

    localparam slot_t LEFT_LAST   = 6'd31;
    localparam slot_t RIGHT_LAST  = 6'd63;
    localparam slot_t LEFT_FIRST  = 6'd0;
    localparam slot_t RIGHT_FIRST = 6'd32;

    // WS leads the data by one slot: it reflects the word owning the slot after s.
    function automatic logic ws_for_slot(input slot_t s);
        slot_t nxt;
        nxt = s + 6'd1;
        return nxt[5];
    endfunction

endpackage

// File: rtl/i2s_modport_clkgen.sv
// SCK divider, slot counter and word-select register shared by both I2S links.
// Built identically whether or not I2S_MODPORT_RX_EN is defined.
module i2s_modport_clkgen
    import i2s_modport_pkg::*;
#(
    parameter int unsigned SCK_DIV = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    output logic       sck,
    output logic       ws,
    output logic       fall_stb,
    output logic       rise_stb,
    output logic [5:0] p,
    output logic [5:0] p_nxt
);

    localparam int unsigned DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;

    assign div_wrap = (div_cnt == DIV_LAST);
    assign fall_stb = div_wrap & sck;
    assign rise_stb = div_wrap & ~sck;
    assign p_nxt    = p + 6'd1;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            div_cnt <= '0;
            sck     <= 1'b0;
            p       <= RIGHT_LAST;
            ws      <= 1'b0;
        end else begin
            if (div_wrap) begin
                div_cnt <= '0;
                sck     <= ~sck;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall_stb) begin
                p  <= p_nxt;
                ws <= ws_for_slot(p_nxt);
            end
        end
    end

endmodule

// File: rtl/i2s_modport.sv
// Dual-link I2S master: 32-bit TX on link 1, 32-bit RX on link 2, one timing generator.
// RX path is built only when `define I2S_MODPORT_RX_EN; otherwise its outputs are tied low.
module i2s_modport
    import i2s_modport_pkg::*;
#(
    parameter int unsigned SCK_DIV = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic [WORD_W-1:0] txm_dat_i,
    output logic              txm_int_o,
    output logic              i2s_sck1,
    output logic              i2s_ws1,
    output logic              i2s_sd1,
    output logic              i2s_sck2,
    output logic              i2s_ws2,
    input  logic              i2s_sd2,
    output logic [WORD_W-1:0] rxm_dat_o,
    output logic              rxm_int_o
);

    logic       sck;
    logic       ws;
    logic       fall_stb;
    logic       rise_stb;
    logic [5:0] p;
    logic [5:0] p_nxt;

    i2s_modport_clkgen #(
        .SCK_DIV(SCK_DIV)
    ) u_clkgen (
        .wb_clk_i (wb_clk_i),
        .wb_rst_ni(wb_rst_ni),
        .sck      (sck),
        .ws       (ws),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb),
        .p        (p),
        .p_nxt    (p_nxt)
    );

    word_t tx_sreg;
    logic  tx_load;

    assign tx_load = fall_stb && (p_nxt == LEFT_FIRST || p_nxt == RIGHT_FIRST);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tx_sreg   <= '0;
            txm_int_o <= 1'b0;
        end else begin
            txm_int_o <= tx_load;
            if (tx_load) begin
                tx_sreg <= txm_dat_i;
            end else if (fall_stb) begin
                tx_sreg <= {tx_sreg[WORD_W-2:0], 1'b0};
            end
        end
    end

    assign i2s_sck1 = sck;
    assign i2s_ws1  = ws;
    assign i2s_sd1  = tx_sreg[WORD_W-1];

`ifdef I2S_MODPORT_RX_EN
    word_t rx_sreg;
    word_t rx_word;
    logic  rx_valid;

    assign rx_word = {rx_sreg[WORD_W-2:0], i2s_sd2};

    // rx_valid arms on entry to slot 0 so the partial slot 63 after reset is never published.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_sreg   <= '0;
            rx_valid  <= 1'b0;
            rxm_dat_o <= '0;
            rxm_int_o <= 1'b0;
        end else begin
            rxm_int_o <= 1'b0;
            if (fall_stb && p_nxt == LEFT_FIRST) begin
                rx_valid <= 1'b1;
            end
            if (rise_stb) begin
                rx_sreg <= rx_word;
                if (rx_valid && (p == LEFT_LAST || p == RIGHT_LAST)) begin
                    rxm_dat_o <= rx_word;
                    rxm_int_o <= 1'b1;
                end
            end
        end
    end

    assign i2s_sck2 = sck;
    assign i2s_ws2  = ws;
`else
    logic unused_rx;

    assign unused_rx = &{1'b0, i2s_sd2, rise_stb, p};
    assign i2s_sck2  = 1'b0;
    assign i2s_ws2   = 1'b0;
    assign rxm_dat_o = '0;
    assign rxm_int_o = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_modport.sv
// Directed self-checking bench for i2s_modport with SCK_DIV = 2 (4-cycle SCK period).
// RX scenarios follow I2S_MODPORT_RX_EN; the compiled-out scenario runs when it is undefined.
module tb_i2s_modport;

    localparam int unsigned SCK_DIV = 2;

    logic        wb_clk_i  = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic [31:0] txm_dat_i = 32'h0;
    logic        txm_int_o;
    logic        i2s_sck1;
    logic        i2s_ws1;
    logic        i2s_sd1;
    logic        i2s_sck2;
    logic        i2s_ws2;
    logic        i2s_sd2   = 1'b0;
    logic [31:0] rxm_dat_o;
    logic        rxm_int_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    i2s_modport #(
        .SCK_DIV(SCK_DIV)
    ) u_dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_ni(wb_rst_ni),
        .txm_dat_i(txm_dat_i),
        .txm_int_o(txm_int_o),
        .i2s_sck1 (i2s_sck1),
        .i2s_ws1  (i2s_ws1),
        .i2s_sd1  (i2s_sd1),
        .i2s_sck2 (i2s_sck2),
        .i2s_ws2  (i2s_ws2),
        .i2s_sd2  (i2s_sd2),
        .rxm_dat_o(rxm_dat_o),
        .rxm_int_o(rxm_int_o)
    );

    task automatic tick;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic do_reset;
        wb_rst_ni = 1'b0;
        tick;
        tick;
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
    endtask

    task automatic test_reset;
        logic exp_sck;
        wb_rst_ni = 1'b0;
        txm_dat_i = 32'hA5A50001;
        i2s_sd2   = 1'b1;
        tick;
        tick;
        n_total++;
        if ({i2s_sck1, i2s_ws1, i2s_sd1, txm_int_o, i2s_sck2, i2s_ws2, rxm_int_o, rxm_dat_o} !== 39'h0) begin
            $display("FAIL reset_outputs: got sck1=%b ws1=%b sd1=%b txi=%b sck2=%b ws2=%b rxi=%b rxd=%h, expected all 0",
                     i2s_sck1, i2s_ws1, i2s_sd1, txm_int_o, i2s_sck2, i2s_ws2, rxm_int_o, rxm_dat_o);
        end else n_pass++;
        n_total++;
        if (u_dut.u_clkgen.p !== 6'd63) $display("FAIL reset_p: got %0d expected 63", u_dut.u_clkgen.p);
        else n_pass++;
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick;
            exp_sck = (c == 2 || c == 3);
            n_total++;
            if (txm_int_o !== (c == 4)) $display("FAIL first_load_c%0d: got txm_int=%b expected %b", c, txm_int_o, (c == 4));
            else n_pass++;
            n_total++;
            if (i2s_sck1 !== exp_sck) $display("FAIL first_sck_c%0d: got %b expected %b", c, i2s_sck1, exp_sck);
            else n_pass++;
            n_total++;
            if (rxm_int_o !== 1'b0) $display("FAIL early_rx_int_c%0d: got %b expected 0", c, rxm_int_o);
            else n_pass++;
        end
        n_total++;
        if (u_dut.u_clkgen.p !== 6'd0) $display("FAIL first_slot_p: got %0d expected 0", u_dut.u_clkgen.p);
        else n_pass++;
        n_total++;
        if (i2s_sd1 !== 1'b1) $display("FAIL first_sd1: got %b expected 1", i2s_sd1);
        else n_pass++;
    endtask

    task automatic test_tx_frame;
        logic [63:0] frame;
        logic        exp_sck;
        logic        exp_ws;
        logic [1:0]  exp_l2;
        int          slot;
        int          last_pulse;
        frame      = {32'hA5A50001, 32'h80000000};
        last_pulse = -1;
        txm_dat_i  = 32'hA5A50001;
        do_reset;
        repeat (4) tick;
        for (int c = 0; c <= 256; c++) begin
            slot    = (c / 4) % 64;
            exp_sck = (c % 4) >= 2;
            exp_ws  = (slot >= 31 && slot <= 62);
`ifdef I2S_MODPORT_RX_EN
            exp_l2  = {exp_sck, exp_ws};
`else
            exp_l2  = 2'b00;
`endif
            if (c == 1)   txm_dat_i = 32'h80000000;
            if (c == 129) txm_dat_i = 32'h00000000;
            n_total++;
            if (txm_int_o !== (c % 128 == 0)) $display("FAIL tx_int_c%0d: got %b expected %b", c, txm_int_o, (c % 128 == 0));
            else n_pass++;
            if (txm_int_o === 1'b1) begin
                if (last_pulse >= 0) begin
                    n_total++;
                    if (c - last_pulse != 128) $display("FAIL tx_int_spacing: got %0d expected 128", c - last_pulse);
                    else n_pass++;
                end
                last_pulse = c;
            end
            n_total++;
            if (i2s_sck1 !== exp_sck) $display("FAIL tx_sck1_c%0d: got %b expected %b", c, i2s_sck1, exp_sck);
            else n_pass++;
            n_total++;
            if (i2s_ws1 !== exp_ws) $display("FAIL ws1_c%0d: got %b expected %b", c, i2s_ws1, exp_ws);
            else n_pass++;
            n_total++;
            if ({i2s_sck2, i2s_ws2} !== exp_l2) $display("FAIL link2_c%0d: got %b expected %b", c, {i2s_sck2, i2s_ws2}, exp_l2);
            else n_pass++;
            if (c % 4 == 0 && c < 256) begin
                n_total++;
                if (i2s_sd1 !== frame[63 - slot]) $display("FAIL sd1_slot%0d: got %b expected %b", slot, i2s_sd1, frame[63 - slot]);
                else n_pass++;
            end
            tick;
        end
    endtask

`ifdef I2S_MODPORT_RX_EN
    task automatic test_rx_frame;
        logic [63:0] rxw;
        logic [31:0] exp_dat;
        rxw     = {32'h12345678, 32'hDEADBEEF};
        i2s_sd2 = 1'b1;
        do_reset;
        for (int c = 1; c <= 4; c++) begin
            tick;
            n_total++;
            if (rxm_int_o !== 1'b0 || rxm_dat_o !== 32'h0)
                $display("FAIL rx_pre_frame_c%0d: got int=%b dat=%h expected 0/00000000", c, rxm_int_o, rxm_dat_o);
            else n_pass++;
        end
        for (int fc = 0; fc < 256; fc++) begin
            if (fc % 4 == 0) i2s_sd2 = rxw[63 - fc / 4];
            exp_dat = (fc < 126) ? 32'h0 : (fc < 254) ? 32'h12345678 : 32'hDEADBEEF;
            n_total++;
            if (rxm_int_o !== (fc == 126 || fc == 254))
                $display("FAIL rx_int_c%0d: got %b expected %b", fc, rxm_int_o, (fc == 126 || fc == 254));
            else n_pass++;
            n_total++;
            if (rxm_dat_o !== exp_dat) $display("FAIL rx_dat_c%0d: got %h expected %h", fc, rxm_dat_o, exp_dat);
            else n_pass++;
            tick;
        end
    endtask
`else
    task automatic test_rx_disabled;
        logic exp_int;
        do_reset;
        for (int c = 0; c < 300; c++) begin
            i2s_sd2 = c[0];
            tick;
            exp_int = (c >= 3) && ((c - 3) % 128 == 0);
            n_total++;
            if ({i2s_sck2, i2s_ws2, rxm_int_o, rxm_dat_o} !== 35'h0)
                $display("FAIL rx_off_c%0d: got sck2=%b ws2=%b int=%b dat=%h expected all 0",
                         c, i2s_sck2, i2s_ws2, rxm_int_o, rxm_dat_o);
            else n_pass++;
            n_total++;
            if (txm_int_o !== exp_int) $display("FAIL rx_off_tx_int_c%0d: got %b expected %b", c, txm_int_o, exp_int);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_reset_mid;
        txm_dat_i = 32'hA5A50001;
        i2s_sd2   = 1'b1;
        do_reset;
        repeat (4 + 160) tick;
        n_total++;
        if (i2s_ws1 !== 1'b1) $display("FAIL mid_ws1_slot40: got %b expected 1", i2s_ws1);
        else n_pass++;
`ifdef I2S_MODPORT_RX_EN
        n_total++;
        if (rxm_dat_o !== 32'hFFFFFFFF) $display("FAIL mid_rx_dat: got %h expected ffffffff", rxm_dat_o);
        else n_pass++;
`endif
        #2;
        wb_rst_ni = 1'b0;
        #1;
        n_total++;
        if ({i2s_sck1, i2s_ws1, i2s_sd1, txm_int_o, i2s_sck2, i2s_ws2, rxm_int_o, rxm_dat_o} !== 39'h0)
            $display("FAIL mid_reset_outputs: got sck1=%b ws1=%b sd1=%b txi=%b rxd=%h expected all 0",
                     i2s_sck1, i2s_ws1, i2s_sd1, txm_int_o, rxm_dat_o);
        else n_pass++;
        n_total++;
        if (u_dut.u_clkgen.p !== 6'd63) $display("FAIL mid_reset_p: got %0d expected 63", u_dut.u_clkgen.p);
        else n_pass++;
        tick;
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        txm_dat_i = 32'hC0000003;
        repeat (4) tick;
        n_total++;
        if (txm_int_o !== 1'b1 || i2s_sd1 !== 1'b1 || i2s_ws1 !== 1'b0)
            $display("FAIL restart_load: got int=%b sd1=%b ws1=%b expected 1/1/0", txm_int_o, i2s_sd1, i2s_ws1);
        else n_pass++;
        n_total++;
        if (u_dut.u_clkgen.p !== 6'd0) $display("FAIL restart_p: got %0d expected 0", u_dut.u_clkgen.p);
        else n_pass++;
        repeat (4) tick;
        n_total++;
        if (i2s_sd1 !== 1'b1) $display("FAIL restart_sd1_slot1: got %b expected 1", i2s_sd1);
        else n_pass++;
        repeat (4) tick;
        n_total++;
        if (i2s_sd1 !== 1'b0) $display("FAIL restart_sd1_slot2: got %b expected 0", i2s_sd1);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_tx_frame;
`ifdef I2S_MODPORT_RX_EN
        test_rx_frame;
`else
        test_rx_disabled;
`endif
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
